// File: rtl/iomem_gpio_bank.sv
// WIDTH-pin GPIO bank on the picosoc iomem bus: direction, atomic set/clear,
// synchronised input readback and per-pin edge interrupts with W1C status.
module iomem_gpio_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin,
    input  logic armed,
    input  logic rise,
    input  logic w1c,
    output logic sync_bit,
    output logic status_bit
);
    logic [SYNC_STAGES-1:0] sq;
    logic                   prev;
    logic                   evt;

    assign sync_bit = sq[SYNC_STAGES-1];
    assign evt = armed && (rise ? (sync_bit && !prev) : (!sync_bit && prev));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sq         <= '0;
            prev       <= 1'b0;
            status_bit <= 1'b0;
        end else begin
            sq         <= {sq[SYNC_STAGES-2:0], pin};
            prev       <= sync_bit;
            // a new event beats a same-cycle clear
            status_bit <= (status_bit && !w1c) || evt;
        end
    end
endmodule

module iomem_gpio_bank #(
    parameter int          WIDTH       = 8,
    parameter logic [7:0]  BASE_HI     = 8'h03,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] RESET_OUT   = 32'd1,
    parameter logic [31:0] RESET_OE    = 32'd1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] out_r, oe_r, mask_r, edge_r;
    logic [WIDTH-1:0] sync_in, status;
    logic [WIDTH-1:0] wd, wm, w1c;
    logic [31:0]      bmask, rd_val;
    logic [2:0]       off, arm_cnt;
    logic             sel, wr, armed;
    logic             unused_ok;

    assign sel   = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_HI);
    assign wr    = sel && (iomem_wstrb != 4'b0);
    assign off   = iomem_addr[4:2];
    assign bmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                    {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign wd    = iomem_wdata[WIDTH-1:0];
    assign wm    = bmask[WIDTH-1:0];
    assign w1c   = (wr && off == 3'd5) ? (wd & wm) : '0;
    assign armed = (arm_cnt == ARM_MAX);

    assign gpio_out  = out_r;
    assign gpio_oe   = oe_r;
    assign unused_ok = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata};

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            iomem_gpio_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
                .clk        (clk),
                .resetn     (resetn),
                .pin        (gpio_in[i]),
                .armed      (armed),
                .rise       (edge_r[i]),
                .w1c        (w1c[i]),
                .sync_bit   (sync_in[i]),
                .status_bit (status[i])
            );
        end
    endgenerate

    // rdata always carries the pre-write value, including on writes
    always_comb begin
        rd_val = '0;
        case (off)
            3'd0:    rd_val[WIDTH-1:0] = out_r;
            3'd1:    rd_val[WIDTH-1:0] = oe_r;
            3'd2:    rd_val[WIDTH-1:0] = sync_in;
            3'd3:    rd_val[WIDTH-1:0] = mask_r;
            3'd4:    rd_val[WIDTH-1:0] = edge_r;
            3'd5:    rd_val[WIDTH-1:0] = status;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_r  <= RESET_OUT[WIDTH-1:0];
            oe_r   <= RESET_OE[WIDTH-1:0];
            mask_r <= '0;
            edge_r <= '1;
        end else if (wr) begin
            case (off)
                3'd0:    out_r  <= (out_r  & ~wm) | (wd & wm);
                3'd1:    oe_r   <= (oe_r   & ~wm) | (wd & wm);
                3'd3:    mask_r <= (mask_r & ~wm) | (wd & wm);
                3'd4:    edge_r <= (edge_r & ~wm) | (wd & wm);
                3'd6:    out_r  <= out_r | (wd & wm);
                3'd7:    out_r  <= out_r & ~(wd & wm);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            irq         <= 1'b0;
            arm_cnt     <= '0;
        end else begin
            iomem_ready <= sel;
            if (sel)
                iomem_rdata <= rd_val;
            irq <= |(status & mask_r);
            // hold off edge detection until the sync chain and history are filled
            if (!armed)
                arm_cnt <= arm_cnt + 3'd1;
        end
    end
endmodule

// File: tb/tb_iomem_gpio_bank.sv
// Directed bench for iomem_gpio_bank: expected read data is queued at issue
// and compared when the ready pulse arrives.
module tb_iomem_gpio_bank;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid8 = 1'b0, valid32 = 1'b0;
    logic        ready8, ready32;
    logic [3:0]  wstrb = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata8, rdata32;
    logic [7:0]  gin8 = 8'hFF, gout8, goe8;
    logic [31:0] gin32 = '0, gout32, goe32;
    logic        irq8, irq32;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    iomem_gpio_bank #(.WIDTH(8)) u_dut (
        .clk(clk), .resetn(resetn), .iomem_valid(valid8), .iomem_ready(ready8),
        .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata),
        .iomem_rdata(rdata8), .gpio_in(gin8), .gpio_out(gout8), .gpio_oe(goe8),
        .irq(irq8)
    );

    iomem_gpio_bank #(.WIDTH(32)) u_dut32 (
        .clk(clk), .resetn(resetn), .iomem_valid(valid32), .iomem_ready(ready32),
        .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata),
        .iomem_rdata(rdata32), .gpio_in(gin32), .gpio_out(gout32), .gpio_oe(goe32),
        .irq(irq32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit w32, input logic [4:0] reg_off, input logic [3:0] ws,
                         input logic [31:0] wd, input logic [31:0] exp_rd);
        addr  = {8'h03, 19'h0, reg_off[2:0], 2'b00};
        wstrb = ws;
        wdata = wd;
        if (w32) valid32 = 1'b1; else valid8 = 1'b1;
        exp_q.push_back(exp_rd);
    endtask

    task automatic collect(input bit w32, input string tag);
        logic [31:0] e;
        bit got;
        got = 0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge clk); #1;
            if ((w32 ? ready32 : ready8) === 1'b1) got = 1;
        end
        e = exp_q.pop_front();
        if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
        else chk(tag, w32 ? rdata32 : rdata8, e);
        valid8 = 1'b0; valid32 = 1'b0; wstrb = '0;
        @(posedge clk); #1;
        chk({tag, "_ready_single"}, {31'd0, (w32 ? ready32 : ready8)}, 32'd0);
    endtask

    task automatic access(input bit w32, input logic [4:0] reg_off, input logic [3:0] ws,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
        @(posedge clk); #1;
        issue(w32, reg_off, ws, wd, exp_rd);
        collect(w32, tag);
    endtask

    initial begin
        bit seen;
        // reset state with pins already high
        #12;
        chk("rst_out", {24'd0, gout8}, 32'h1);
        chk("rst_oe", {24'd0, goe8}, 32'h1);
        chk("rst_irq", {31'd0, irq8}, 32'd0);
        chk("rst_ready", {31'd0, ready8}, 32'd0);
        chk("rst_rdata", rdata8, 32'd0);
        @(negedge clk); resetn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("arm_irq", {31'd0, irq8}, 32'd0);
        access(0, 5, 4'h0, 0, 32'h0, "arm_status");
        access(0, 2, 4'h0, 0, 32'hFF, "in_read");

        // OUT write with old value returned, then SET/CLR
        access(0, 0, 4'b0001, 32'hA5, 32'h1, "out_wr");
        chk("gpio_out_a5", {24'd0, gout8}, 32'hA5);
        access(0, 6, 4'hF, 32'h0A, 32'h0, "set_wr");
        chk("gpio_out_af", {24'd0, gout8}, 32'hAF);
        access(0, 7, 4'hF, 32'h21, 32'h0, "clr_wr");
        chk("gpio_out_8e", {24'd0, gout8}, 32'h8E);
        access(0, 1, 4'h0, 0, 32'h1, "oe_read");
        access(0, 4, 4'h0, 0, 32'hFF, "edge_read");
        access(0, 7, 4'h0, 0, 32'h0, "clr_read0");

        // byte strobes
        access(1, 0, 4'hF, 32'h0, 32'h1, "w32_out_clear");
        access(1, 0, 4'b0100, 32'h11223344, 32'h0, "w32_byte_wr");
        access(1, 0, 4'h0, 0, 32'h00220000, "w32_byte_rd");
        access(0, 0, 4'b0100, 32'hFFFFFFFF, 32'h8E, "w8_hi_byte_wr");
        access(0, 0, 4'h0, 0, 32'h8E, "w8_hi_byte_rd");

        // rising edge on pin 0 with mask set
        @(posedge clk); #1; gin8[0] = 1'b0;
        repeat (5) @(posedge clk);
        access(0, 3, 4'hF, 32'h1, 32'h0, "mask_wr");
        access(0, 5, 4'h0, 0, 32'h0, "status_after_fall");
        @(posedge clk); #1; gin8[0] = 1'b1;
        seen = 0;
        for (int n = 0; n < 4 && !seen; n++) begin
            @(posedge clk); #1;
            if (irq8) seen = 1;
        end
        chk("irq_latency", {31'd0, seen}, 32'd1);
        access(0, 5, 4'h0, 0, 32'h1, "status_rise");
        access(0, 5, 4'hF, 32'h1, 32'h1, "status_w1c");
        chk("irq_cleared", {31'd0, irq8}, 32'd0);
        access(0, 5, 4'h0, 0, 32'h0, "status_zero");

        // falling edge on pin 3, masked off then unmasked
        access(0, 4, 4'hF, 32'hF7, 32'hFF, "edge_wr");
        @(posedge clk); #1; gin8[3] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("irq_masked", {31'd0, irq8}, 32'd0);
        access(0, 5, 4'h0, 0, 32'h8, "status_fall");
        access(0, 3, 4'hF, 32'h9, 32'h1, "mask_wr9");
        chk("irq_unmasked", {31'd0, irq8}, 32'd1);

        // W1C colliding with a new rising edge on pin 0
        access(0, 5, 4'hF, 32'h9, 32'h8, "status_clr_all");
        @(posedge clk); #1; gin8[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1; gin8[0] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        issue(0, 5, 4'hF, 32'h1, 32'h0);
        collect(0, "w1c_collide");
        access(0, 5, 4'h0, 0, 32'h1, "set_wins");

        // other window: no response, no change
        @(posedge clk); #1;
        addr = 32'h04000000; wstrb = 4'hF; wdata = 32'hFF; valid8 = 1'b1;
        seen = 0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (ready8) seen = 1;
        end
        valid8 = 1'b0; wstrb = '0;
        chk("unsel_ready", {31'd0, seen}, 32'd0);
        chk("unsel_out", {24'd0, gout8}, 32'h8E);

        // alias through the ignored address bits
        @(posedge clk); #1;
        addr = 32'h03ABCDE0; wstrb = 4'h0; valid8 = 1'b1;
        exp_q.push_back(32'h8E);
        collect(0, "alias_read");

        // reset in the middle of a write
        @(posedge clk); #1;
        issue(0, 0, 4'hF, 32'hFF, 32'h0);
        void'(exp_q.pop_back());
        #2 resetn = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, ready8}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_out", {24'd0, gout8}, 32'h1);
        chk("midrst_ready2", {31'd0, ready8}, 32'd0);
        valid8 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
